// File: rtl/imem_load_ctrl.sv
// Packs UART bytes little-endian into words and writes them to IMEM while holding the CPU in reset.
// Latency: imem_wr one cycle after a word's 4th byte; never backpressures, accepts a byte every cycle.
module imem_load_ctrl #(
    parameter int ADDR_WIDTH     = 16,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_imem,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  imem_wr,
    output logic [ADDR_WIDTH-3:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [3:0]            imem_byte_en,
    output logic                  cpu_hold,
    output logic                  load_busy,
    output logic [ADDR_WIDTH:0]   byte_cnt,
    output logic                  overflow
);
    localparam int             WAW       = ADDR_WIDTH - 2;
    localparam logic [WAW-1:0] LAST_WORD = '1;
    localparam logic [7:0]     REL_LAST  = 8'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        FLUSH   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]            lane;
    logic [1:0]            lane_nxt;
    logic [WAW-1:0]        word_addr;
    logic [WAW-1:0]        word_addr_nxt;
    logic                  full;
    logic                  full_nxt;
    logic [23:0]           asm_buf;
    logic [23:0]           asm_buf_nxt;
    logic [7:0]            rel_cnt;
    logic [7:0]            rel_cnt_nxt;
    logic                  wr_nxt;
    logic [WAW-1:0]        addr_nxt;
    logic [31:0]           wdata_nxt;
    logic [3:0]            be_nxt;
    logic [ADDR_WIDTH:0]   byte_cnt_nxt;
    logic                  overflow_nxt;
    logic                  start_session;

    // A session may start from IDLE or restart from RELEASE without dropping cpu_hold.
    assign start_session = load_imem && ((state == IDLE) || (state == RELEASE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_imem) state_nxt = LOAD;
            end
            LOAD: begin
                if (!load_imem) state_nxt = FLUSH;
            end
            FLUSH: begin
                state_nxt = RELEASE;
            end
            RELEASE: begin
                if (load_imem) begin
                    state_nxt = LOAD;
                end else if (rel_cnt == REL_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_nxt        = 1'b0;
        be_nxt        = 4'h0;
        addr_nxt      = imem_addr;
        wdata_nxt     = imem_wdata;
        lane_nxt      = lane;
        word_addr_nxt = word_addr;
        full_nxt      = full;
        asm_buf_nxt   = asm_buf;
        byte_cnt_nxt  = byte_cnt;
        overflow_nxt  = overflow;
        rel_cnt_nxt   = 8'd0;

        if (start_session) begin
            lane_nxt      = 2'd0;
            word_addr_nxt = '0;
            full_nxt      = 1'b0;
            byte_cnt_nxt  = '0;
            overflow_nxt  = 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (rx_valid) begin
                        if (full) begin
                            overflow_nxt = 1'b1;
                        end else begin
                            byte_cnt_nxt = byte_cnt + 1'b1;
                            if (lane == 2'd3) begin
                                wr_nxt    = 1'b1;
                                be_nxt    = 4'hF;
                                addr_nxt  = word_addr;
                                wdata_nxt = {rx_data, asm_buf};
                                lane_nxt  = 2'd0;
                                // The last word pins the address instead of wrapping to 0.
                                if (word_addr == LAST_WORD) begin
                                    full_nxt = 1'b1;
                                end else begin
                                    word_addr_nxt = word_addr + 1'b1;
                                end
                            end else begin
                                asm_buf_nxt[{lane, 3'b000} +: 8] = rx_data;
                                lane_nxt = lane + 1'b1;
                            end
                        end
                    end
                end
                FLUSH: begin
                    lane_nxt = 2'd0;
                    if ((lane != 2'd0) && !full) begin
                        wr_nxt   = 1'b1;
                        addr_nxt = word_addr;
                        // Lanes not yet written this word may hold stale bytes; zero them.
                        case (lane)
                            2'd1: begin
                                be_nxt    = 4'b0001;
                                wdata_nxt = {24'h0, asm_buf[7:0]};
                            end
                            2'd2: begin
                                be_nxt    = 4'b0011;
                                wdata_nxt = {16'h0, asm_buf[15:0]};
                            end
                            default: begin
                                be_nxt    = 4'b0111;
                                wdata_nxt = {8'h0, asm_buf[23:0]};
                            end
                        endcase
                    end
                end
                RELEASE: begin
                    if (rel_cnt != REL_LAST) rel_cnt_nxt = rel_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_wr      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'h0;
            imem_byte_en <= 4'h0;
            cpu_hold     <= 1'b0;
            load_busy    <= 1'b0;
            byte_cnt     <= '0;
            overflow     <= 1'b0;
            lane         <= 2'd0;
            word_addr    <= '0;
            full         <= 1'b0;
            asm_buf      <= 24'h0;
            rel_cnt      <= 8'd0;
        end else begin
            imem_wr      <= wr_nxt;
            imem_addr    <= addr_nxt;
            imem_wdata   <= wdata_nxt;
            imem_byte_en <= be_nxt;
            cpu_hold     <= (state_nxt != IDLE);
            load_busy    <= (state_nxt != IDLE);
            byte_cnt     <= byte_cnt_nxt;
            overflow     <= overflow_nxt;
            lane         <= lane_nxt;
            word_addr    <= word_addr_nxt;
            full         <= full_nxt;
            asm_buf      <= asm_buf_nxt;
            rel_cnt      <= rel_cnt_nxt;
        end
    end

endmodule
